// File: rtl/fb_branch_predictor.sv
// Purpose : direct-mapped dynamic branch predictor (tag, target, 2-bit counter per line).
// Latency : lookup, flush and redirect are combinational; training lands on the next rising edge.
// Backpr. : none; every resolved control instruction is consumed in its own cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   if_pc                fetch pc looked up combinationally
//   pred_taken, pred_pc  prediction for if_pc
//   ex_*                 resolved instruction from EX plus the prediction it carried
//   inv                  synchronous invalidate-all (fence.i)
//   flush, redirect_pc   misprediction flush and corrected fetch pc
//   br_cnt, mis_cnt      wrapping perf counters: resolved control insts / mispredictions
module fb_branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_pc,
  input  logic            inv,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mis_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W;

  localparam logic [XLEN-1:0] PC_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  // Table state
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];

  logic [31:0] br_cnt_q,  br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // ---------------------------------------------------------------------------
  // Lookup (IF stage)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W-1:0];
  assign if_tag = if_pc[XLEN-1:IDX_W];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Reset clears every valid bit asynchronously, so the lookup falls back to
  // the fall-through pc during and after reset without extra gating.
  assign pred_taken = if_hit && cnt_q[if_idx][1];
  assign pred_pc    = pred_taken ? tgt_q[if_idx] : (if_pc + PC_ONE);

  // ---------------------------------------------------------------------------
  // Resolve (EX stage)
  // ---------------------------------------------------------------------------
  logic ctl;
  logic mis;

  assign ctl = ex_valid && (ex_is_branch || ex_is_jump);
  assign mis = ctl && ((ex_pred_taken != ex_taken) ||
                       (ex_taken && (ex_pred_pc != ex_target)));

  // Not gated by rst: the pipeline's own reset masks these.
  assign flush       = mis;
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + PC_ONE);

  // ---------------------------------------------------------------------------
  // Training: compute the new contents of line ex_idx
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_jmp;
  logic [1:0]       ex_cnt_old;

  logic             wr_en_d;
  logic [1:0]       wr_cnt_d;
  logic [XLEN-1:0]  wr_tgt_d;

  assign ex_idx     = ex_pc[IDX_W-1:0];
  assign ex_tag     = ex_pc[XLEN-1:IDX_W];
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_cnt_old = cnt_q[ex_idx];
  // Branch and jump both set is illegal; the jump interpretation wins.
  assign ex_jmp     = ex_is_jump;

  always_comb begin
    wr_en_d  = 1'b0;
    wr_cnt_d = ex_cnt_old;
    wr_tgt_d = tgt_q[ex_idx];
    if (ctl) begin
      if (ex_hit) begin
        wr_en_d = 1'b1;
        if (ex_jmp) begin
          wr_cnt_d = 2'b11;
          wr_tgt_d = ex_target;
        end else if (ex_taken) begin
          wr_cnt_d = (ex_cnt_old == 2'b11) ? 2'b11 : (ex_cnt_old + 2'd1);
          wr_tgt_d = ex_target;
        end else begin
          wr_cnt_d = (ex_cnt_old == 2'b00) ? 2'b00 : (ex_cnt_old - 2'd1);
        end
      end else if (ex_taken) begin
        // Allocate, evicting whatever line aliased onto this index.
        wr_en_d  = 1'b1;
        wr_cnt_d = ex_jmp ? 2'b11 : 2'b10;
        wr_tgt_d = ex_target;
      end
    end
  end

  // Perf counters keep counting even when inv drops the table write.
  assign br_cnt_d  = ctl ? (br_cnt_q  + 32'd1) : br_cnt_q;
  assign mis_cnt_d = mis ? (mis_cnt_q + 32'd1) : mis_cnt_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (inv) begin
      // Invalidate-all overrides any same-cycle training write.
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_d) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      tgt_q[ex_idx]   <= wr_tgt_d;
      cnt_q[ex_idx]   <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

endmodule

// File: doc/fb_branch_predictor.md
# fb_branch_predictor

Dynamic branch predictor for the Firebird pipeline, replacing the static backward-taken/forward-not-taken scheme. It holds a direct-mapped table of ENTRIES lines, each with a tag, a target and a 2-bit saturating counter. The IF stage looks the table up combinationally. The EX stage resolves control instructions, raises a flush with the corrected pc on a misprediction, and trains the table on the following clock edge. PCs are word addresses, so the fall-through is pc + 1.

## Interface
- XLEN, 32: pc/target width.
- ENTRIES, 16: table lines; a power of two, ≥ 2. IDX_W = log2(ENTRIES).
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch pc.
- pred_taken  out  1  predicted taken for if_pc.
- pred_pc  out  XLEN  predicted next pc.
- ex_valid  in  1  the EX stage holds a resolved instruction.
- ex_pc  in  XLEN  pc of that instruction.
- ex_is_branch  in  1  the instruction is B-type.
- ex_is_jump  in  1  the instruction is jal/jalr.
- ex_taken  in  1  actual outcome (1 for jumps).
- ex_target  in  XLEN  actual taken target.
- ex_pred_taken  in  1  pred_taken carried down the pipe.
- ex_pred_pc  in  XLEN  pred_pc carried down the pipe.
- inv  in  1  synchronous invalidate-all (fence.i).
- flush  out  1  misprediction: reset IF/ID, ID/EX and EX/MEM.
- redirect_pc  out  XLEN  corrected fetch pc; valid when flush = 1.
- br_cnt  out  32  resolved control instructions (wrapping).
- mis_cnt  out  32  mispredictions (wrapping).

## Operation
- Address fields: idx = pc[IDX_W-1:0], tag = pc[XLEN-1:IDX_W].
- Lookup:
  - hit = valid[idx] & (tag[idx] == if_pc tag).
  - pred_taken = hit & cnt[idx][1].
  - pred_pc = pred_taken ? target[idx] : if_pc + 1. The addition is modulo 2^XLEN.
- Resolve: ctl = ex_valid & (ex_is_branch | ex_is_jump).
- Mispredict: mis = ctl & ((ex_pred_taken != ex_taken) | (ex_taken & ex_pred_pc != ex_target)).
- Flush outputs: flush = mis; redirect_pc = ex_taken ? ex_target : ex_pc + 1.
- Update on ctl, at line ex_pc idx:
  - Tag hit, branch: the counter increments on taken and decrements on not-taken, saturating at 3 and 0. If taken, target ← ex_target.
  - Tag hit, jump: counter ← 3 and target ← ex_target.
  - Tag miss and taken: allocate the line, overwriting any prior owner. valid ← 1, tag and target are written, counter ← 2'b10 for a branch or 2'b11 for a jump.
  - Tag miss and not taken: no change.
- inv: all valid bits clear at the next edge. inv overrides a same-cycle update, which is dropped. The perf counters still count that update.
- Perf counters: br_cnt += ctl and mis_cnt += mis, both wrapping at 2^32.
- ex_is_branch and ex_is_jump both set is illegal. If it happens, the line is treated as a jump.

## Timing
- Lookup, flush and redirect_pc are combinational; there is zero-cycle latency from their inputs.
- Training takes effect at the rising edge after ctl. A lookup in the same cycle sees the pre-update contents; there is no bypass.
- Reset (asynchronous, at any time, including mid-update):
  - All valid bits = 0, all counters = CNT_INIT, all tags and targets = 0.
  - br_cnt = mis_cnt = 0.
  - Outputs during and after reset: pred_taken = 0, pred_pc = if_pc + 1.
  - flush and redirect_pc follow the EX inputs combinationally even during reset. The pipeline's own reset masks them.
- No handshake: every ctl cycle is consumed, so back-to-back resolutions update on consecutive edges.
- Update and lookup at the same idx in the same cycle: lookup returns the old line and the write lands at the edge.

## Test plan
- Reset: rst pulse, then if_pc = 0x40 → pred_taken = 0, pred_pc = 0x41, br_cnt = mis_cnt = 0.
- Allocate and redirect: resolve ex_pc = 0x40 as a branch, taken, ex_target = 0x30, ex_pred_taken = 0.
  - Same cycle: flush = 1, redirect_pc = 0x30.
  - Next cycle: br_cnt = 1, mis_cnt = 1; if_pc = 0x40 → pred_taken = 1, pred_pc = 0x30.
- Hysteresis and saturation:
  - Line 0x40 at counter 2'b10, one not-taken → pred_taken = 0.
  - Four taken (counter 3), then one not-taken → pred_taken still 1, and flush = 1 on that not-taken cycle with redirect_pc = 0x41.
- Aliasing (ENTRIES = 16):
  - With 0x40 allocated, if_pc = 0x50 → miss, pred_pc = 0x51.
  - Resolve 0x50 taken to 0x80 → 0x50 predicts 0x80 and 0x40 now misses.
  - A not-taken miss at 0x60 leaves 0x50 intact.
- jalr target change: line 0x20 holds jump target 0x100. Resolve a jump with ex_target = 0x200, ex_pred_taken = 1, ex_pred_pc = 0x100 → flush = 1, redirect_pc = 0x200; the next lookup of 0x20 gives 0x200.
- inv and reset races:
  - inv together with a taken update of 0x70 → all lookups miss next cycle, and br_cnt still increments.
  - rst asserted between two back-to-back updates → table cleared immediately and the second update is lost while rst is high.
